// File: rtl/hazard_scoreboard_if.sv
// DX-side bundle of the hazard scoreboard: pipeline control, DX instruction
// fields in, forwarding selects / stall / perf counters out.
interface hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
);
    logic                    freeze;
    logic                    flush;
    logic                    clr_cnt;
    logic                    dx_valid;
    logic [NUM_SRC*RA_W-1:0] dx_src_addr;
    logic [NUM_SRC-1:0]      dx_src_used;
    logic [RA_W-1:0]         dx_dst_addr;
    logic                    dx_writes_rf;
    logic                    dx_is_load;
    logic [NUM_SRC*2-1:0]    fwd_sel;
    logic                    stall;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        fwd_cnt;

    modport master (
        output freeze, flush, clr_cnt, dx_valid, dx_src_addr, dx_src_used,
               dx_dst_addr, dx_writes_rf, dx_is_load,
        input  fwd_sel, stall, stall_cnt, fwd_cnt
    );

    modport slave (
        input  freeze, flush, clr_cnt, dx_valid, dx_src_addr, dx_src_used,
               dx_dst_addr, dx_writes_rf, dx_is_load,
        output fwd_sel, stall, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow XM/MW writer tracking beside DX: per-operand forwarding selects,
// load-use stall and saturating stall/forward counters.
module hazard_scoreboard_lane #(
    parameter int RA_W        = 5,
    parameter int ZERO_REG_EN = 1
) (
    input  logic            dx_valid,
    input  logic            src_used,
    input  logic [RA_W-1:0] src_addr,
    input  logic            xm_valid,
    input  logic [RA_W-1:0] xm_dst,
    input  logic            xm_is_load,
    input  logic            mw_valid,
    input  logic [RA_W-1:0] mw_dst,
    output logic [1:0]      sel_raw,
    output logic            load_hit
);
    logic eligible, xm_hit, mw_hit;

    assign eligible = dx_valid && src_used && !((ZERO_REG_EN != 0) && (src_addr == '0));
    assign xm_hit   = eligible && xm_valid && (xm_dst == src_addr);
    assign mw_hit   = eligible && mw_valid && (mw_dst == src_addr);
    assign load_hit = xm_hit && xm_is_load;

    // Any XM match shadows MW, even a load that cannot forward yet.
    always_comb begin
        sel_raw = 2'b00;
        if (xm_hit) sel_raw = xm_is_load ? 2'b00 : 2'b10;
        else if (mw_hit) sel_raw = 2'b01;
    end
endmodule

module hazard_scoreboard #(
    parameter int NUM_SRC     = 2,
    parameter int RA_W        = 5,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               n_reset,
    hazard_scoreboard_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] dst;
        logic            is_load;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ent_t                       xm, mw;
    logic [NUM_SRC-1:0][1:0]    sel_raw;
    logic [NUM_SRC-1:0]         load_hit;
    logic                       stall_int, fwd_evt, dst_zero, xm_take;
    logic [CNT_W-1:0]           stall_cnt_q, fwd_cnt_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        hazard_scoreboard_lane #(
            .RA_W        (RA_W),
            .ZERO_REG_EN (ZERO_REG_EN)
        ) u_lane (
            .dx_valid   (bus.dx_valid),
            .src_used   (bus.dx_src_used[i]),
            .src_addr   (bus.dx_src_addr[i*RA_W +: RA_W]),
            .xm_valid   (xm.valid),
            .xm_dst     (xm.dst),
            .xm_is_load (xm.is_load),
            .mw_valid   (mw.valid),
            .mw_dst     (mw.dst),
            .sel_raw    (sel_raw[i]),
            .load_hit   (load_hit[i])
        );
    end

    assign stall_int = !bus.flush && (|load_hit);
    assign fwd_evt   = bus.dx_valid && !stall_int && !bus.flush && (|sel_raw);
    assign dst_zero  = (ZERO_REG_EN != 0) && (bus.dx_dst_addr == '0);
    // A stalled or flushed DX slot becomes the bubble that enters XM.
    assign xm_take   = bus.dx_valid && bus.dx_writes_rf && !stall_int && !bus.flush && !dst_zero;

    assign bus.stall     = stall_int;
    assign bus.fwd_sel   = stall_int ? '0 : sel_raw;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            xm <= '0;
            mw <= '0;
        end else if (!bus.freeze) begin
            mw       <= xm;
            xm.valid <= xm_take;
            xm.dst   <= bus.dx_dst_addr;
            xm.is_load <= bus.dx_is_load;
        end
    end

    // Clear beats increment and is honoured even while frozen.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (bus.clr_cnt) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (!bus.freeze) begin
            if (stall_int && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (fwd_evt && fwd_cnt_q != CNT_MAX)     fwd_cnt_q   <= fwd_cnt_q + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Two scoreboards (ZERO_REG_EN=1/CNT_W=16 and ZERO_REG_EN=0/CNT_W=2) driven
// in lockstep and compared against a history-based reference model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    logic       freeze = 0, flush = 0, clr = 0, dv = 0, wr = 0, ld = 0;
    logic [9:0] sa = '0;
    logic [1:0] su = '0;
    logic [4:0] dd = '0;

    hazard_scoreboard_if #(.NUM_SRC(2), .RA_W(5), .CNT_W(16)) ia ();
    hazard_scoreboard_if #(.NUM_SRC(2), .RA_W(5), .CNT_W(2))  ib ();

    assign ia.freeze = freeze;  assign ib.freeze = freeze;
    assign ia.flush = flush;    assign ib.flush = flush;
    assign ia.clr_cnt = clr;    assign ib.clr_cnt = clr;
    assign ia.dx_valid = dv;    assign ib.dx_valid = dv;
    assign ia.dx_src_addr = sa; assign ib.dx_src_addr = sa;
    assign ia.dx_src_used = su; assign ib.dx_src_used = su;
    assign ia.dx_dst_addr = dd; assign ib.dx_dst_addr = dd;
    assign ia.dx_writes_rf = wr; assign ib.dx_writes_rf = wr;
    assign ia.dx_is_load = ld;  assign ib.dx_is_load = ld;

    hazard_scoreboard #(.NUM_SRC(2), .RA_W(5), .ZERO_REG_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .n_reset(n_reset), .bus(ia));
    hazard_scoreboard #(.NUM_SRC(2), .RA_W(5), .ZERO_REG_EN(0), .CNT_W(2)) u_b (
        .clk(clk), .n_reset(n_reset), .bus(ib));

    // Model: the last two issued writers per DUT, index 0 = youngest.
    logic       hv[2][2];
    logic [4:0] hd[2][2];
    logic       hl[2][2];
    int         ecs[2], ecf[2];
    int         zen[2] = '{1, 0};
    int         cmax[2] = '{65535, 3};
    int         checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_eval(input int k, output logic [3:0] sel, output logic st);
        logic hit_ld;
        logic [4:0] a;
        sel = '0;
        hit_ld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = sa[i*5 +: 5];
            if (dv && su[i] && !(zen[k] != 0 && a == 0)) begin
                // youngest writer of this register decides
                if (hv[k][0] && hd[k][0] == a) begin
                    if (hl[k][0]) hit_ld = 1'b1;
                    else sel[i*2 +: 2] = 2'b10;
                end else if (hv[k][1] && hd[k][1] == a) begin
                    sel[i*2 +: 2] = 2'b01;
                end
            end
        end
        st = !flush && hit_ld;
        if (st) sel = '0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++) begin
                hv[k][j] = 0; hd[k][j] = 0; hl[k][j] = 0;
            end
            ecs[k] = 0; ecf[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k);
        logic [3:0] sel;
        logic st;
        model_eval(k, sel, st);
        if (clr) begin
            ecs[k] = 0; ecf[k] = 0;
        end else if (!freeze) begin
            if (st && ecs[k] < cmax[k]) ecs[k]++;
            if (dv && !st && !flush && sel != 0 && ecf[k] < cmax[k]) ecf[k]++;
        end
        if (!freeze) begin
            hv[k][1] = hv[k][0]; hd[k][1] = hd[k][0]; hl[k][1] = hl[k][0];
            hv[k][0] = dv && wr && !st && !flush && !(zen[k] != 0 && dd == 0);
            hd[k][0] = dd; hl[k][0] = ld;
        end
    endfunction

    task automatic sample();
        logic [3:0] sel;
        logic st;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_eval(k, sel, st);
            chk(k == 0 ? "a.fwd_sel" : "b.fwd_sel", k == 0 ? 32'(ia.fwd_sel) : 32'(ib.fwd_sel), 32'(sel));
            chk(k == 0 ? "a.stall" : "b.stall", k == 0 ? 32'(ia.stall) : 32'(ib.stall), 32'(st));
            chk(k == 0 ? "a.stall_cnt" : "b.stall_cnt", k == 0 ? 32'(ia.stall_cnt) : 32'(ib.stall_cnt), 32'(ecs[k]));
            chk(k == 0 ? "a.fwd_cnt" : "b.fwd_cnt", k == 0 ? 32'(ia.fwd_cnt) : 32'(ib.fwd_cnt), 32'(ecf[k]));
        end
    endtask

    task automatic adv();
        if (!n_reset) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] u, input logic [4:0] d, input logic w, input logic l);
        dv = v; sa = {s1, s0}; su = u; dd = d; wr = w; ld = l;
        freeze = 0; flush = 0; clr = 0;
    endtask

    task automatic idle();
        issue(0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        idle();
        sample();
        chk("rst.fwd_sel", 32'(ia.fwd_sel), 0);
        chk("rst.stall", 32'(ia.stall), 0);
        adv();
        n_reset = 1;

        // ALU chain: add r3; sub r5,r3,r3; read r3
        issue(1, 1, 2, 2'b11, 3, 1, 0); sample(); adv();
        issue(1, 3, 3, 2'b11, 5, 1, 0); sample();
        chk("alu.xm_both", 32'(ia.fwd_sel), 32'h0000_000A); adv();
        issue(1, 3, 0, 2'b01, 0, 0, 0); sample();
        chk("alu.mw", 32'(ia.fwd_sel[1:0]), 32'h1); adv();

        // Load-use: lw r4; add r6,r4,r1 held one cycle
        issue(1, 0, 0, 2'b00, 4, 1, 1); clr = 1; sample(); adv();
        issue(1, 4, 1, 2'b11, 6, 1, 0); sample();
        chk("lu.stall", 32'(ia.stall), 1); adv();
        issue(1, 4, 1, 2'b11, 6, 1, 0); sample();
        chk("lu.after_stall", 32'(ia.stall), 0);
        chk("lu.mw_sel", 32'(ia.fwd_sel[1:0]), 32'h1); adv();
        idle(); sample();
        chk("lu.stall_cnt", 32'(ia.stall_cnt), 1);
        chk("lu.fwd_cnt", 32'(ia.fwd_cnt), 1); adv();

        // Zero register: write then read r0, then load r0 then read
        issue(1, 0, 0, 2'b00, 0, 1, 0); sample(); adv();
        issue(1, 0, 0, 2'b01, 1, 0, 0); sample();
        chk("zero.en1", 32'(ia.fwd_sel), 0);
        chk("zero.en0", 32'(ib.fwd_sel), 32'h2); adv();
        issue(1, 0, 0, 2'b00, 0, 1, 1); sample(); adv();
        issue(1, 0, 0, 2'b01, 1, 0, 0); sample();
        chk("zero.ld_en1", 32'(ia.stall), 0);
        chk("zero.ld_en0", 32'(ib.stall), 1); adv();
        idle(); sample(); adv();

        // Priority: r7 written twice, then read
        issue(1, 0, 0, 2'b00, 7, 1, 0); sample(); adv();
        issue(1, 0, 0, 2'b00, 7, 1, 0); sample(); adv();
        issue(1, 7, 0, 2'b01, 2, 1, 0); sample();
        chk("prio.xm", 32'(ia.fwd_sel[1:0]), 32'h2); adv();

        // Flush on a would-be load-use cycle
        issue(1, 0, 0, 2'b00, 4, 1, 1); sample(); adv();
        issue(1, 4, 0, 2'b01, 6, 1, 0); flush = 1; sample();
        chk("flush.stall", 32'(ia.stall), 0); adv();
        issue(1, 4, 0, 2'b01, 6, 1, 0); sample();
        chk("flush.stall2", 32'(ia.stall), 0);
        chk("flush.mw", 32'(ia.fwd_sel[1:0]), 32'h1); adv();

        // Freeze 3 cycles with the load in XM
        issue(1, 0, 0, 2'b00, 4, 1, 1); sample(); adv();
        for (int i = 0; i < 3; i++) begin
            issue(1, 4, 0, 2'b01, 6, 1, 0); freeze = 1; sample();
            chk("frz.stall", 32'(ia.stall), 1);
            chk("frz.stall_cnt", 32'(ia.stall_cnt), 1); adv();
        end
        issue(1, 4, 0, 2'b01, 6, 1, 0); sample(); adv();
        issue(1, 4, 0, 2'b01, 6, 1, 0); sample();
        chk("frz.release", 32'(ia.fwd_sel[1:0]), 32'h1);
        chk("frz.stall_cnt2", 32'(ia.stall_cnt), 2); adv();

        // Saturation: 5 load-use stalls after a clear
        idle(); clr = 1; sample(); adv();
        for (int i = 0; i < 5; i++) begin
            issue(1, 0, 0, 2'b00, 9, 1, 1); sample(); adv();
            issue(1, 9, 0, 2'b01, 10, 0, 0); sample(); adv();
            issue(1, 9, 0, 2'b01, 10, 0, 0); sample(); adv();
        end
        idle(); sample();
        chk("sat.b_stall", 32'(ib.stall_cnt), 3);
        chk("sat.a_stall", 32'(ia.stall_cnt), 5);
        chk("sat.b_fwd", 32'(ib.fwd_cnt), 3); adv();
        idle(); clr = 1; sample(); adv();
        idle(); sample();
        chk("clr.stall_cnt", 32'(ia.stall_cnt), 0);
        chk("clr.fwd_cnt", 32'(ia.fwd_cnt), 0); adv();

        // Asynchronous reset mid-stall
        issue(1, 0, 0, 2'b00, 4, 1, 1); sample(); adv();
        issue(1, 4, 4, 2'b11, 6, 1, 0);
        #2;
        chk("arst.pre_stall", 32'(ia.stall), 1);
        n_reset = 0;
        #1;
        chk("arst.stall", 32'(ia.stall), 0);
        chk("arst.fwd_sel", 32'(ia.fwd_sel), 0);
        chk("arst.b_stall", 32'(ib.stall), 0);
        model_reset();
        sample(); adv();
        n_reset = 1;

        // Randomized traffic over a small register set to force hazards
        for (int n = 0; n < 400; n++) begin
            dv = ($urandom_range(0, 3) != 0);
            sa = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            su = 2'($urandom_range(0, 3));
            dd = 5'($urandom_range(0, 3));
            wr = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 29) == 0);
            sample(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the two-operand forwarding unit.
- Keeps its own shadow copy of the XM and MW destination-register state. Per source operand, it generates forwarding selects, a load-use stall, and saturating performance counters.
- Sits beside the DX stage. Only the DX instruction fields are fed in; the block tracks in-flight writers itself and obeys pipeline stall, freeze and flush.

Parameters:
- NUM_SRC, 2, number of source operands checked per DX instruction.
- RA_W, 5, register address width.
- ZERO_REG_EN, 1, when 1, register 0 is never matched for forwarding or stall.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock.
- n_reset  in  1  asynchronous active-low reset.
- freeze  in  1  whole pipeline held (memory busy); shadow state and counters hold.
- flush  in  1  DX instruction killed this cycle (branch redirect).
- clr_cnt  in  1  synchronous clear of both counters.
- dx_valid  in  1  DX holds a real instruction.
- dx_src_addr  in  NUM_SRC*RA_W  source register addresses; operand i is at bits [i*RA_W +: RA_W].
- dx_src_used  in  NUM_SRC  operand i is actually read.
- dx_dst_addr  in  RA_W  destination register.
- dx_writes_rf  in  1  DX instruction writes the register file.
- dx_is_load  in  1  DX instruction is a load (data available only after MEM).
- fwd_sel  out  NUM_SRC*2  per operand: 2'b10 = from XM, 2'b01 = from MW, 2'b00 = from register file.
- stall  out  1  hold IF/DX and inject a bubble into XM.
- stall_cnt  out  CNT_W  cycles spent in load-use stall.
- fwd_cnt  out  CNT_W  issued instructions that used at least one forward.

Behaviour:
- Shadow state: entries XM and MW, each holding {valid, dst, is_load}.
- Reset: all shadow entries invalid; stall_cnt = 0; fwd_cnt = 0. Consequently fwd_sel = 0 and stall = 0 during and immediately after reset. Reset mid-operation discards all in-flight tracking.
- Operand i is eligible when dx_valid && dx_src_used[i] && !(ZERO_REG_EN && addr == 0).
- Match definitions:
  - XM match: XM.valid && XM.dst == addr.
  - MW match: MW.valid && MW.dst == addr.
- fwd_sel[i] (combinational, zero latency):
  - eligible && XM match && !XM.is_load -> 2'b10.
  - else eligible && MW match, with no XM match at all -> 2'b01. The younger writer always wins.
  - otherwise -> 2'b00.
- Load-use:
  - stall = !flush && any eligible operand has an XM match with XM.is_load.
  - When stall is 1, all fwd_sel fields are forced to 2'b00.
  - A dependent on a load stalls for exactly 1 cycle. The load then sits in MW and the dependent receives 2'b01.
- Shadow update, on rising clk when freeze = 0:
  - MW <= XM, always.
  - XM <= invalid if stall or flush or !dx_valid or !dx_writes_rf.
  - Otherwise XM <= {1, dx_dst_addr, dx_is_load}. A DX write to register 0 with ZERO_REG_EN = 1 is captured as invalid.
- freeze = 1: all shadow entries and counters hold. fwd_sel and stall remain combinational functions of the current state and inputs.
- flush with stall conditions present: flush wins, so stall = 0 and XM receives a bubble. The XM -> MW move still occurs, because the older instruction survives.
- Counters, when freeze = 0:
  - stall_cnt increments each cycle stall = 1.
  - fwd_cnt increments each cycle dx_valid && !stall && !flush && at least one fwd_sel != 0.
  - Both saturate at 2^CNT_W - 1 with no wrap.
  - clr_cnt has priority over increment and applies even under freeze.
- Simultaneous XM and MW writers to the same register: XM is selected. If XM is a load, stall.
- Both operands matching different stages is legal, e.g. src0 -> 2'b10 and src1 -> 2'b01 in the same cycle.

Test Plan:
- ALU forwarding chains: add r3 issued, then sub r5,r3,r3 the next cycle -> fwd_sel = 4'b1010. On the following cycle, an instruction reading r3 -> fwd_sel field 2'b01.
- Load-use: lw r4, then add r6,r4,r1 -> stall = 1 for one cycle, stall_cnt = 1. The next cycle gives fwd_sel[1:0] = 2'b01 and stall = 0; fwd_cnt = 1.
- Zero register: r0 written then read with ZERO_REG_EN = 1 -> fwd_sel = 0, stall = 0. With ZERO_REG_EN = 0 -> 2'b10.
- Priority: r7 written twice back-to-back, then r7 read -> 2'b10 (XM), not 2'b01.
- Flush and freeze:
  - Flush asserted during a would-be load-use cycle -> stall = 0, XM bubble inserted.
  - freeze = 1 for 3 cycles while the load is in XM -> stall stays 1, stall_cnt unchanged, shadow state held.
- Reset and saturation:
  - Drop n_reset asynchronously mid-stall -> stall and fwd_sel fall to 0 immediately.
  - With CNT_W = 2 and 5 stall cycles -> stall_cnt = 3.
  - clr_cnt -> both counters = 0 next cycle.
